// File: rtl/adc_frame_aligner.sv
// Frame-clock training, lock supervision and sample capture for deserialised LVDS ADC lanes.
// Issues bitslip pulses until the frame word matches, then delivers formatted, valid-qualified samples.
module adc_frame_aligner #(
    parameter int              NCH       = 4,
    parameter int              DW        = 16,
    parameter logic [DW-1:0]   FRAME_PAT = 16'hFF00,
    parameter int              LOCK_CNT  = 16,
    parameter int              SLIP_WAIT = 8,
    parameter int              MAX_SLIPS = DW,
    parameter int              LOSS_CNT  = 4,
    parameter int              PIPE      = 2
) (
    input  logic                             clk_adc,
    input  logic                             rst_n,
    input  logic [NCH*DW-1:0]                din,
    input  logic [DW-1:0]                    frame_in,
    input  logic                             retrain,
    input  logic                             fmt_twos,
    output logic                             bitslip,
    output logic                             locked,
    output logic                             train_fail,
    output logic [$clog2(MAX_SLIPS+1)-1:0]   slip_count,
    output logic [15:0]                      err_cnt,
    output logic [NCH*DW-1:0]                dout,
    output logic                             dout_valid
);

    localparam int SCW = $clog2(MAX_SLIPS + 1);
    localparam int MCW = $clog2(LOCK_CNT + 1);
    localparam int WCW = $clog2(SLIP_WAIT + 1);
    localparam int LCW = $clog2(LOSS_CNT + 1);

    localparam logic [SCW-1:0] SLIP_MAX   = SCW'(MAX_SLIPS);
    localparam logic [MCW-1:0] MATCH_LAST = MCW'(LOCK_CNT - 1);
    localparam logic [WCW-1:0] WAIT_LAST  = WCW'(SLIP_WAIT - 1);
    localparam logic [LCW-1:0] LOSS_LAST  = LCW'(LOSS_CNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SLIP,
        S_WAIT,
        S_LOCKED,
        S_FAIL
    } state_t;

    state_t           state;
    logic [MCW-1:0]   match_cnt;
    logic [WCW-1:0]   wait_cnt;
    logic [LCW-1:0]   miss_cnt;
    logic             frame_ok;

    assign frame_ok = (frame_in == FRAME_PAT);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_adc) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            bitslip    <= 1'b0;
            locked     <= 1'b0;
            train_fail <= 1'b0;
            slip_count <= '0;
            err_cnt    <= '0;
            match_cnt  <= '0;
            wait_cnt   <= '0;
            miss_cnt   <= '0;
        end else if (retrain) begin
            state      <= S_IDLE;
            bitslip    <= 1'b0;
            locked     <= 1'b0;
            train_fail <= 1'b0;
        end else begin
            bitslip <= 1'b0;
            case (state)
                S_IDLE: begin
                    match_cnt  <= '0;
                    slip_count <= '0;
                    err_cnt    <= '0;
                    miss_cnt   <= '0;
                    state      <= S_CHECK;
                end
                S_CHECK: begin
                    if (frame_ok) begin
                        if (match_cnt == MATCH_LAST) begin
                            match_cnt <= '0;
                            miss_cnt  <= '0;
                            locked    <= 1'b1;
                            state     <= S_LOCKED;
                        end else begin
                            match_cnt <= match_cnt + 1'b1;
                        end
                    end else begin
                        match_cnt <= '0;
                        if (slip_count < SLIP_MAX) begin
                            bitslip <= 1'b1;
                            state   <= S_SLIP;
                        end else begin
                            train_fail <= 1'b1;
                            state      <= S_FAIL;
                        end
                    end
                end
                S_SLIP: begin
                    slip_count <= slip_count + 1'b1;
                    wait_cnt   <= '0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    // Frame word is untrustworthy while the ISERDES settles after a slip.
                    if (wait_cnt == WAIT_LAST) begin
                        match_cnt <= '0;
                        state     <= S_CHECK;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (frame_ok) begin
                        miss_cnt <= '0;
                    end else begin
                        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
                        if (miss_cnt == LOSS_LAST) begin
                            locked <= 1'b0;
                            state  <= S_IDLE;
                        end else begin
                            miss_cnt <= miss_cnt + 1'b1;
                        end
                    end
                end
                S_FAIL: begin
                    state <= S_FAIL;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [NCH*DW-1:0] msb_mask;
    logic [NCH*DW-1:0] stage_in;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        msb_mask = '0;
        for (int k = 0; k < NCH; k++) msb_mask[k*DW + DW - 1] = fmt_twos;
        stage_in = din ^ msb_mask;
    end

    logic [NCH*DW-1:0] pipe [PIPE];
    logic [PIPE-1:0]   vpipe;

    // NOTE: the pipeline registers are reset so dout_valid drops in the first cycle after reset.
    always_ff @(posedge clk_adc) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE; i++) pipe[i] <= '0;
            vpipe <= '0;
        end else begin
            pipe[0]  <= stage_in;
            vpipe[0] <= locked;
            for (int i = 1; i < PIPE; i++) begin
                pipe[i]  <= pipe[i-1];
                vpipe[i] <= vpipe[i-1];
            end
        end
    end

    assign dout_valid = vpipe[PIPE-1];
    assign dout       = dout_valid ? pipe[PIPE-1] : '0;

endmodule

// File: tb/tb_adc_frame_aligner.sv
// Directed bench for adc_frame_aligner: an ISERDES rotation model drives frame_in,
// and a scoreboard queue holds expected samples until they leave the data pipeline.
module tb_adc_frame_aligner;

    localparam int NCH       = 4;
    localparam int DW        = 16;
    localparam int PIPE      = 2;
    localparam int SLIP_WAIT = 8;
    localparam logic [63:0] FMT_IN  = {16'h1111, 16'h2222, 16'h7FFF, 16'h8000};
    localparam logic [63:0] FMT_EXP = {16'h9111, 16'hA222, 16'hFFFF, 16'h0000};

    logic              clk_adc;
    logic              rst_n;
    logic [63:0]       din;
    logic [15:0]       frame_in;
    logic              retrain;
    logic              fmt_twos;
    logic              bitslip;
    logic              locked;
    logic              train_fail;
    logic [4:0]        slip_count;
    logic [15:0]       err_cnt;
    logic [63:0]       dout;
    logic              dout_valid;

    adc_frame_aligner #(
        .NCH(NCH), .DW(DW), .FRAME_PAT(16'hFF00), .LOCK_CNT(16), .SLIP_WAIT(SLIP_WAIT),
        .MAX_SLIPS(16), .LOSS_CNT(4), .PIPE(PIPE)
    ) dut (
        .clk_adc    (clk_adc),
        .rst_n      (rst_n),
        .din        (din),
        .frame_in   (frame_in),
        .retrain    (retrain),
        .fmt_twos   (fmt_twos),
        .bitslip    (bitslip),
        .locked     (locked),
        .train_fail (train_fail),
        .slip_count (slip_count),
        .err_cnt    (err_cnt),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    initial clk_adc = 1'b0;
    always #5 clk_adc = ~clk_adc;

    int n_pass  = 0;
    int n_total = 0;

    // ISERDES model: source word rotated left by rot_init, each bitslip rotates it back by one.
    logic [15:0] frame_src   = 16'hFF00;
    int          rot_init    = 0;
    int          pulse_base  = 0;
    int          pulse_total = 0;
    int          cyc         = 0;
    int          last_pulse  = -1;
    int          min_gap     = 1000000;

    function automatic logic [15:0] rotl16(input logic [15:0] v, input int r);
        int s;
        s = ((r % 16) + 16) % 16;
        return (v << s) | (v >> (16 - s));
    endfunction

    assign frame_in = rotl16(frame_src, rot_init - (pulse_total - pulse_base));

    always @(negedge clk_adc) begin
        cyc++;
        if (bitslip) begin
            pulse_total++;
            if (last_pulse >= 0 && (cyc - last_pulse) < min_gap) min_gap = cyc - last_pulse;
            last_pulse = cyc;
        end
    end

    typedef struct {
        logic [63:0] data;
        int          tick;
    } sb_entry_t;

    sb_entry_t exp_q[$];
    int        sb_tick = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance past exactly one rising edge; land mid-low-phase.
    task automatic step_cycle();
        @(negedge clk_adc);
        #1;
    endtask

    function automatic logic [63:0] fmt_model(input logic [63:0] w, input logic f);
        logic [63:0] r;
        r = w;
        if (f) begin
            for (int k = 0; k < NCH; k++) r[k*16 + 15] = ~r[k*16 + 15];
        end
        return r;
    endfunction

    task automatic sb_step(input bit drv, input logic [63:0] w, input logic f, input logic [63:0] e);
        sb_entry_t ent;
        step_cycle();
        sb_tick++;
        if (exp_q.size() > 0 && (sb_tick - exp_q[0].tick) == PIPE) begin
            ent = exp_q.pop_front();
            check("dout_data", dout, ent.data);
            check("dout_valid_stream", dout_valid, 1'b1);
        end
        if (drv) begin
            din      = w;
            fmt_twos = f;
            ent.data = e;
            ent.tick = sb_tick;
            exp_q.push_back(ent);
        end
    endtask

    task automatic wait_locked(input string tag, input int budget);
        for (int i = 0; i < budget && !locked; i++) step_cycle();
        check(tag, locked, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bitslip"},    bitslip,    1'b0);
        check({tag, "_locked"},     locked,     1'b0);
        check({tag, "_train_fail"}, train_fail, 1'b0);
        check({tag, "_slip_count"}, slip_count, 5'd0);
        check({tag, "_err_cnt"},    err_cnt,    16'd0);
        check({tag, "_dout"},       dout,       64'd0);
        check({tag, "_dout_valid"}, dout_valid, 1'b0);
    endtask

    initial begin
        logic [63:0] w;

        rst_n    = 1'b0;
        retrain  = 1'b0;
        fmt_twos = 1'b0;
        din      = '0;
        repeat (3) step_cycle();
        check_all_zero("reset");

        // Aligned start: IDLE at the last reset edge, locked after 17 more edges.
        din   = 64'h0123_4567_89AB_CDEF;
        rst_n = 1'b1;
        repeat (16) step_cycle();
        check("locked_before_edge17", locked, 1'b0);
        step_cycle();
        check("locked_after_edge17", locked, 1'b1);
        check("aligned_slip_count", slip_count, 5'd0);
        check("aligned_no_pulses", pulse_total - pulse_base, 0);
        step_cycle();
        check("valid_lag1", dout_valid, 1'b0);
        step_cycle();
        check("valid_lag2", dout_valid, 1'b1);
        check("dout_after_lock", dout, 64'h0123_4567_89AB_CDEF);

        // Streamed samples through the scoreboard, then the format corner values.
        for (int i = 0; i < 8; i++) begin
            w = {$urandom, $urandom};
            sb_step(1'b1, w, i[0], fmt_model(w, i[0]));
        end
        sb_step(1'b1, FMT_IN, 1'b1, FMT_EXP);
        sb_step(1'b1, FMT_IN, 1'b0, FMT_IN);
        for (int i = 0; i < PIPE + 1 && exp_q.size() > 0; i++) sb_step(1'b0, '0, 1'b0, '0);
        check("sb_drained", exp_q.size(), 0);

        // Lock loss: three misses are tolerated, four drop lock.
        check("err_cnt_clean", err_cnt, 16'd0);
        frame_src = 16'h0F0F;
        repeat (3) step_cycle();
        frame_src = 16'hFF00;
        step_cycle();
        check("locked_after_3_miss", locked, 1'b1);
        check("err_cnt_3", err_cnt, 16'd3);
        frame_src = 16'h0F0F;
        repeat (4) step_cycle();
        check("locked_after_4_miss", locked, 1'b0);
        frame_src = 16'hFF00;
        step_cycle();
        check("err_cnt_cleared", err_cnt, 16'd0);
        step_cycle();
        check("valid_after_loss", dout_valid, 1'b0);
        check("dout_masked", dout, 64'd0);
        wait_locked("relock_after_loss", 40);
        check("relock_slip_count", slip_count, 5'd0);

        // Rotated frame: three slips bring the pattern into place.
        retrain    = 1'b1;
        rot_init   = 3;
        pulse_base = pulse_total;
        step_cycle();
        retrain = 1'b0;
        check("retrain_clears_lock", locked, 1'b0);
        wait_locked("rotated_lock", 200);
        check("rotated_pulses", pulse_total - pulse_base, 3);
        check("rotated_slip_count", slip_count, 5'd3);

        // Never-aligning frame: 16 slips, then FAIL with no further pulses.
        retrain    = 1'b1;
        frame_src  = 16'h1234;
        rot_init   = 0;
        pulse_base = pulse_total;
        step_cycle();
        retrain = 1'b0;
        for (int i = 0; i < 400 && !train_fail; i++) step_cycle();
        check("train_fail_set", train_fail, 1'b1);
        check("fail_pulses", pulse_total - pulse_base, 16);
        check("fail_slip_count", slip_count, 5'd16);
        check("fail_not_locked", locked, 1'b0);
        repeat (30) step_cycle();
        check("fail_no_more_pulses", pulse_total - pulse_base, 16);
        check("fail_held", train_fail, 1'b1);
        check("fail_slip_count_held", slip_count, 5'd16);
        check("min_pulse_gap_ok", min_gap >= SLIP_WAIT + 2, 1'b1);

        retrain    = 1'b1;
        frame_src  = 16'hFF00;
        pulse_base = pulse_total;
        step_cycle();
        retrain = 1'b0;
        check("retrain_clears_fail", train_fail, 1'b0);
        step_cycle();
        check("idle_clears_slip_count", slip_count, 5'd0);
        wait_locked("relock_after_fail", 40);

        // Reset while settling after a slip.
        retrain    = 1'b1;
        rot_init   = 5;
        pulse_base = pulse_total;
        step_cycle();
        retrain = 1'b0;
        for (int i = 0; i < 50 && (pulse_total - pulse_base) < 1; i++) step_cycle();
        check("first_pulse_seen", pulse_total - pulse_base, 1);
        repeat (3) step_cycle();
        check("slip_count_in_wait", slip_count, 5'd1);
        rst_n = 1'b0;
        step_cycle();
        check_all_zero("reset_in_wait");
        rst_n      = 1'b1;
        rot_init   = 2;
        pulse_base = pulse_total;
        wait_locked("lock_after_reset", 150);
        check("post_reset_slip_count", slip_count, 5'd2);
        check("post_reset_pulses", pulse_total - pulse_base, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
